// File: rtl/proc_ctrl_regs_pkg.sv
// Shared constants for the processor special-register block: PSR bit map,
// implemented-bit mask and PC sequencing encodings.
package proc_pkg;

   localparam int unsigned C_IND = 0;
   localparam int unsigned L_IND = 2;
   localparam int unsigned F_IND = 5;
   localparam int unsigned Z_IND = 6;
   localparam int unsigned N_IND = 7;
   localparam int unsigned E_IND = 9;

   // Highest implemented bit is E, so DATA_W must be at least 10.
   localparam logic [15:0] PSR_IMPL_MASK = 16'h02E5;

   typedef enum logic [1:0] {
      PCM_HOLD = 2'd0,
      PCM_INC  = 2'd1,
      PCM_LOAD = 2'd2,
      PCM_REL  = 2'd3
   } pc_mode_e;

endpackage

// File: rtl/proc_ctrl_regs_if.sv
// Bus between the control FSM/datapath (master) and the special-register
// block (slave).
interface proc_ctrl_regs_if
   import proc_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned PC_W   = 16
);
   pc_mode_e            pc_mode;
   logic [PC_W-1:0]     pc_in;
   logic [PC_W-1:0]     pc_disp;
   logic                instr_en;
   logic [DATA_W-1:0]   instr_in;
   logic                cmp_f_en;
   logic                of_f_en;
   logic                z_f_en;
   logic                C_in;
   logic                L_in;
   logic                F_in;
   logic                Z_in;
   logic                N_in;
   logic                psr_wr_en;
   logic [DATA_W-1:0]   psr_in;
   logic                int_req;
   logic [PC_W-1:0]     int_vector;
   logic                ret_en;

   logic [DATA_W-1:0]   psr;
   logic [DATA_W-1:0]   instr;
   logic [PC_W-1:0]     pc;
   logic                int_ack;
   logic                stack_full;
   logic                stack_empty;
   logic                stack_err;

   modport master (
      output pc_mode, pc_in, pc_disp, instr_en, instr_in,
             cmp_f_en, of_f_en, z_f_en, C_in, L_in, F_in, Z_in, N_in,
             psr_wr_en, psr_in, int_req, int_vector, ret_en,
      input  psr, instr, pc, int_ack, stack_full, stack_empty, stack_err
   );

   modport slave (
      input  pc_mode, pc_in, pc_disp, instr_en, instr_in,
             cmp_f_en, of_f_en, z_f_en, C_in, L_in, F_in, Z_in, N_in,
             psr_wr_en, psr_in, int_req, int_vector, ret_en,
      output psr, instr, pc, int_ack, stack_full, stack_empty, stack_err
   );

endinterface

// File: rtl/proc_ctrl_regs_int_shadow_stack.sv
// LIFO of saved {PC, PSR} frames for interrupt entry/return. Caller never
// pushes and pops in the same cycle; contents are not reset, only the count.
module int_shadow_stack #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] top_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CNT_W-1:0] count_q, count_d;
   logic [IDX_W-1:0] wr_idx, rd_idx;

   assign wr_idx  = count_q[IDX_W-1:0];
   assign rd_idx  = wr_idx - IDX_W'(1);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign top_o   = mem_q[rd_idx];

   always_comb begin
      count_d = count_q;
      if (push_i && !full_o) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop_i && !empty_o) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !full_o) begin
         mem_q[wr_idx] <= data_i;
      end
   end

endmodule

// File: rtl/proc_ctrl_regs.sv
// Processor special registers (PSR, PC, INSTR) with PC sequencing and
// hardware interrupt entry/return through a shadow stack.
module proc_ctrl_regs
   import proc_pkg::*;
#(
   parameter int unsigned        DATA_W    = 16,
   parameter int unsigned        PC_W      = 16,
   parameter int unsigned        INT_DEPTH = 4,
   parameter logic [PC_W-1:0]    RESET_PC  = '0
) (
   input  logic              clk,
   input  logic              reset,
   proc_ctrl_regs_if.slave   bus
);

   localparam int unsigned       STK_W    = PC_W + DATA_W;
   localparam logic [DATA_W-1:0] PSR_MASK = DATA_W'(PSR_IMPL_MASK);

   logic [PC_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0] psr_q, psr_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic              int_ack_q, int_ack_d;
   logic              stack_err_q, stack_err_d;

   logic              push, pop;
   logic              int_take;
   logic              stk_full, stk_empty;
   logic [STK_W-1:0]  stk_top;

   assign int_take = bus.int_req & psr_q[E_IND] & ~stk_full & ~bus.ret_en;

   always_comb begin
      pc_d        = pc_q;
      psr_d       = psr_q;
      instr_d     = bus.instr_en ? bus.instr_in : instr_q;
      int_ack_d   = 1'b0;
      stack_err_d = stack_err_q;
      push        = 1'b0;
      pop         = 1'b0;

      if (bus.ret_en && !stk_empty) begin
         pop   = 1'b1;
         pc_d  = stk_top[STK_W-1:DATA_W];
         psr_d = stk_top[DATA_W-1:0] & PSR_MASK;
      end else if (int_take) begin
         push          = 1'b1;
         pc_d          = bus.int_vector;
         psr_d[E_IND]  = 1'b0;
         int_ack_d     = 1'b1;
      end else begin
         // A return on an empty stack is flagged but otherwise behaves as a
         // normal cycle.
         if (bus.ret_en) begin
            stack_err_d = 1'b1;
         end

         case (bus.pc_mode)
            PCM_INC:  pc_d = pc_q + PC_W'(1);
            PCM_LOAD: pc_d = bus.pc_in;
            PCM_REL:  pc_d = pc_q + bus.pc_disp;
            default:  pc_d = pc_q;
         endcase

         if (bus.psr_wr_en) begin
            psr_d = bus.psr_in & PSR_MASK;
         end else begin
            if (bus.cmp_f_en) begin
               psr_d[L_IND] = bus.L_in;
               psr_d[N_IND] = bus.N_in;
            end
            if (bus.of_f_en) begin
               psr_d[F_IND] = bus.F_in;
               psr_d[C_IND] = bus.C_in;
            end
            if (bus.z_f_en) begin
               psr_d[Z_IND] = bus.Z_in;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         psr_q       <= '0;
         instr_q     <= '0;
         int_ack_q   <= 1'b0;
         stack_err_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         psr_q       <= psr_d;
         instr_q     <= instr_d;
         int_ack_q   <= int_ack_d;
         stack_err_q <= stack_err_d;
      end
   end

   int_shadow_stack #(
      .WIDTH (STK_W),
      .DEPTH (INT_DEPTH)
   ) u_stack (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  ({pc_q, psr_q}),
      .top_o   (stk_top),
      .full_o  (stk_full),
      .empty_o (stk_empty)
   );

   assign bus.pc          = pc_q;
   assign bus.psr         = psr_q;
   assign bus.instr       = instr_q;
   assign bus.int_ack     = int_ack_q;
   assign bus.stack_err   = stack_err_q;
   assign bus.stack_full  = stk_full;
   assign bus.stack_empty = stk_empty;

endmodule

// File: tb/tb_proc_ctrl_regs.sv
// Table-driven bench for proc_ctrl_regs with INT_DEPTH=2 and a non-zero
// reset PC; expected frames are queued at drive time and popped after the edge.
module tb_proc_ctrl_regs;
   import proc_pkg::*;

   localparam int unsigned DW    = 16;
   localparam int unsigned PW    = 16;
   localparam int unsigned DEPTH = 2;
   localparam logic [15:0] RPC   = 16'h0040;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] psr;
      logic [15:0] instr;
      logic        ack;
      logic        full;
      logic        empty;
      logic        err;
   } exp_t;

   typedef struct packed {
      logic        rst;
      logic [1:0]  mode;
      logic [15:0] pc_in;
      logic [15:0] disp;
      logic        ien;
      logic [15:0] iin;
      logic        cmp;
      logic        of;
      logic        z;
      logic [4:0]  flg;   // {N, Z, F, L, C}
      logic        wr;
      logic [15:0] psr_in;
      logic        req;
      logic [15:0] vec;
      logic        ret;
      exp_t        e;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   proc_ctrl_regs_if #(.DATA_W(DW), .PC_W(PW)) bus ();

   proc_ctrl_regs #(
      .DATA_W    (DW),
      .PC_W      (PW),
      .INT_DEPTH (DEPTH),
      .RESET_PC  (RPC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   vec_t  tbl[$];
   string names[$];
   exp_t  sb_q[$];
   string sb_name[$];
   int    n_pass  = 0;
   int    n_total = 0;

   function automatic exp_t mk(input logic [15:0] pc, input logic [15:0] psr,
                               input logic [15:0] instr, input logic ack,
                               input logic full, input logic empty, input logic err);
      exp_t e;
      e.pc = pc; e.psr = psr; e.instr = instr;
      e.ack = ack; e.full = full; e.empty = empty; e.err = err;
      return e;
   endfunction

   function automatic vec_t dflt();
      vec_t v = '0;
      return v;
   endfunction

   task automatic add(input string nm, input vec_t v);
      tbl.push_back(v);
      names.push_back(nm);
   endtask

   task automatic drive(input vec_t v);
      reset          = v.rst;
      bus.pc_mode    = pc_mode_e'(v.mode);
      bus.pc_in      = v.pc_in;
      bus.pc_disp    = v.disp;
      bus.instr_en   = v.ien;
      bus.instr_in   = v.iin;
      bus.cmp_f_en   = v.cmp;
      bus.of_f_en    = v.of;
      bus.z_f_en     = v.z;
      bus.C_in       = v.flg[0];
      bus.L_in       = v.flg[1];
      bus.F_in       = v.flg[2];
      bus.Z_in       = v.flg[3];
      bus.N_in       = v.flg[4];
      bus.psr_wr_en  = v.wr;
      bus.psr_in     = v.psr_in;
      bus.int_req    = v.req;
      bus.int_vector = v.vec;
      bus.ret_en     = v.ret;
   endtask

   task automatic sample(output exp_t g);
      g.pc    = bus.pc;
      g.psr   = bus.psr;
      g.instr = bus.instr;
      g.ack   = bus.int_ack;
      g.full  = bus.stack_full;
      g.empty = bus.stack_empty;
      g.err   = bus.stack_err;
   endtask

   task automatic check(input string nm, input exp_t got, input exp_t exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got pc=%h psr=%h instr=%h ack=%b full=%b empty=%b err=%b, expected pc=%h psr=%h instr=%h ack=%b full=%b empty=%b err=%b",
                  nm, got.pc, got.psr, got.instr, got.ack, got.full, got.empty, got.err,
                  exp.pc, exp.psr, exp.instr, exp.ack, exp.full, exp.empty, exp.err);
      end
   endtask

   task automatic check_int(input string nm, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      exp_t g;
      int   cyc;
      logic got_ack;

      v = dflt(); v.rst = 1'b1;
      v.e = mk(16'h0040, 16'h0000, 16'h0000, 0, 0, 1, 0);               add("reset", v);
      v = dflt(); v.mode = PCM_LOAD; v.pc_in = 16'hFFFF;
      v.e = mk(16'hFFFF, 16'h0000, 16'h0000, 0, 0, 1, 0);               add("load_ffff", v);
      v = dflt(); v.mode = PCM_INC;
      v.e = mk(16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0);               add("inc_wrap", v);
      v = dflt(); v.mode = PCM_LOAD; v.pc_in = 16'h0010;
      v.e = mk(16'h0010, 16'h0000, 16'h0000, 0, 0, 1, 0);               add("load_0010", v);
      v = dflt(); v.mode = PCM_REL; v.disp = 16'hFFF0;
      v.e = mk(16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0);               add("rel_neg_wrap", v);
      v = dflt(); v.mode = PCM_LOAD; v.pc_in = 16'h1234; v.ien = 1'b1; v.iin = 16'hABCD;
      v.e = mk(16'h1234, 16'h0000, 16'hABCD, 0, 0, 1, 0);               add("load_1234", v);
      v = dflt(); v.iin = 16'h9999;
      v.e = mk(16'h1234, 16'h0000, 16'hABCD, 0, 0, 1, 0);               add("hold", v);
      v = dflt(); v.cmp = 1'b1; v.z = 1'b1; v.flg = 5'b11111;
      v.e = mk(16'h1234, 16'h00C4, 16'hABCD, 0, 0, 1, 0);               add("flags_cmp_z", v);
      v = dflt(); v.wr = 1'b1; v.psr_in = 16'hFFFF; v.of = 1'b1; v.flg = 5'b00000;
      v.e = mk(16'h1234, 16'h02E5, 16'hABCD, 0, 0, 1, 0);               add("psr_wr_over_of", v);
      v = dflt(); v.of = 1'b1; v.flg = 5'b11010;
      v.e = mk(16'h1234, 16'h02C4, 16'hABCD, 0, 0, 1, 0);               add("of_clear_fc", v);
      v = dflt(); v.wr = 1'b1; v.psr_in = 16'h0204; v.mode = PCM_LOAD; v.pc_in = 16'h0100;
      v.e = mk(16'h0100, 16'h0204, 16'hABCD, 0, 0, 1, 0);               add("setup_int", v);
      v = dflt(); v.req = 1'b1; v.vec = 16'h0800; v.mode = PCM_INC; v.wr = 1'b1;
      v.e = mk(16'h0800, 16'h0004, 16'hABCD, 1, 0, 0, 0);               add("int_entry", v);
      v = dflt(); v.req = 1'b1; v.vec = 16'h0800;
      v.e = mk(16'h0800, 16'h0004, 16'hABCD, 0, 0, 0, 0);               add("ack_one_cycle", v);
      v = dflt(); v.ret = 1'b1; v.mode = PCM_LOAD; v.pc_in = 16'h5555; v.cmp = 1'b1; v.flg = 5'b11111;
      v.e = mk(16'h0100, 16'h0204, 16'hABCD, 0, 0, 1, 0);               add("retx", v);
      v = dflt(); v.req = 1'b1; v.vec = 16'h0800;
      v.e = mk(16'h0800, 16'h0004, 16'hABCD, 1, 0, 0, 0);               add("int1", v);
      v = dflt(); v.wr = 1'b1; v.psr_in = 16'h0200; v.mode = PCM_INC;
      v.e = mk(16'h0801, 16'h0200, 16'hABCD, 0, 0, 0, 0);               add("set_e1", v);
      v = dflt(); v.req = 1'b1; v.vec = 16'h0900;
      v.e = mk(16'h0900, 16'h0000, 16'hABCD, 1, 1, 0, 0);               add("int2_full", v);
      v = dflt(); v.wr = 1'b1; v.psr_in = 16'h0200;
      v.e = mk(16'h0900, 16'h0200, 16'hABCD, 0, 1, 0, 0);               add("set_e2", v);
      v = dflt(); v.req = 1'b1; v.vec = 16'h0A00; v.mode = PCM_INC;
      v.e = mk(16'h0901, 16'h0200, 16'hABCD, 0, 1, 0, 0);               add("int3_blocked", v);
      v = dflt(); v.req = 1'b1; v.vec = 16'h0A00;
      v.e = mk(16'h0901, 16'h0200, 16'hABCD, 0, 1, 0, 0);               add("int3_still_blocked", v);
      v = dflt(); v.req = 1'b1; v.vec = 16'h0A00; v.ret = 1'b1;
      v.e = mk(16'h0801, 16'h0200, 16'hABCD, 0, 0, 0, 0);               add("ret_beats_req", v);
      v = dflt(); v.req = 1'b1; v.vec = 16'h0A00;
      v.e = mk(16'h0A00, 16'h0000, 16'hABCD, 1, 1, 0, 0);               add("int_after_ret", v);
      v = dflt(); v.rst = 1'b1; v.req = 1'b1; v.ret = 1'b1; v.mode = PCM_INC; v.wr = 1'b1; v.psr_in = 16'hFFFF;
      v.e = mk(16'h0040, 16'h0000, 16'h0000, 0, 0, 1, 0);               add("reset_mid_nest", v);
      v = dflt(); v.ret = 1'b1; v.mode = PCM_LOAD; v.pc_in = 16'h2222; v.cmp = 1'b1; v.flg = 5'b11111;
      v.e = mk(16'h2222, 16'h0084, 16'h0000, 0, 0, 1, 1);               add("ret_empty", v);
      v = dflt(); v.mode = PCM_INC; v.ien = 1'b1; v.iin = 16'h1357;
      v.e = mk(16'h2223, 16'h0084, 16'h1357, 0, 0, 1, 1);               add("err_sticky", v);
      v = dflt(); v.ret = 1'b1; v.wr = 1'b1; v.psr_in = 16'h0200;
      v.e = mk(16'h2223, 16'h0200, 16'h1357, 0, 0, 1, 1);               add("ret_empty_psr_wr", v);
      v = dflt(); v.req = 1'b1; v.vec = 16'h0300;
      v.e = mk(16'h0300, 16'h0000, 16'h1357, 1, 0, 0, 1);               add("int_with_err", v);
      v = dflt(); v.rst = 1'b1;
      v.e = mk(16'h0040, 16'h0000, 16'h0000, 0, 0, 1, 0);               add("reset_clears_err", v);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         sb_q.push_back(tbl[i].e);
         sb_name.push_back(names[i]);
         @(posedge clk);
         #1;
         sample(g);
         check(sb_name.pop_front(), g, sb_q.pop_front());
      end

      // Level request held across several cycles: accepted once, not retaken.
      v = dflt(); v.wr = 1'b1; v.psr_in = 16'h0200;
      drive(v);
      @(posedge clk); #1;
      sample(g);
      check("hs_set_e", g, mk(16'h0040, 16'h0200, 16'h0000, 0, 0, 1, 0));

      v = dflt(); v.req = 1'b1; v.vec = 16'h0777; v.mode = PCM_INC;
      drive(v);
      cyc = 0;
      got_ack = 1'b0;
      while (!got_ack && cyc < 8) begin
         @(posedge clk); #1;
         cyc++;
         if (bus.int_ack === 1'b1) got_ack = 1'b1;
      end
      check_int("hs_ack_latency", got_ack ? cyc : -1, 1);
      sample(g);
      check("hs_entry", g, mk(16'h0777, 16'h0000, 16'h0000, 1, 0, 0, 0));

      @(posedge clk); #1;
      sample(g);
      check("hs_no_retake", g, mk(16'h0778, 16'h0000, 16'h0000, 0, 0, 0, 0));

      v = dflt(); v.ret = 1'b1;
      drive(v);
      @(posedge clk); #1;
      sample(g);
      check("hs_return", g, mk(16'h0040, 16'h0200, 16'h0000, 0, 0, 1, 0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
